// File: rtl/vld_word_serializer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : vld_word_serializer_pkg
// Desc   : State encoding, default word width and clog2 helper for the serializer.
// Rev    : 1.0
// ----------------------------------------------------------------------------
package vld_word_serializer_pkg;

  localparam int c_DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vld_word_serializer_sat_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : vld_word_serializer_sat_counter
// Desc   : Saturating up-counter with synchronous active-low clear.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module vld_word_serializer_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/vld_word_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : vld_word_serializer
// Desc   : Serializes a strobed wide frame into valid-qualified words with SOF/EOF.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module vld_word_serializer
  import vld_word_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
  parameter int NUM_WORDS  = 4,
  parameter int GAP_CYCLES = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [NUM_WORDS*DATA_WIDTH-1:0] frame_in,
  input  logic                            frame_in_vld,
  output logic                            busy,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic                            data_out_vld,
  output logic                            data_out_sof,
  output logic                            data_out_eof,
  output logic [CNT_WIDTH-1:0]            drop_cnt
);

  localparam int c_IDX_W = clog2(NUM_WORDS);
  localparam int c_GAP_W = (clog2(GAP_CYCLES + 1) > 1) ? clog2(GAP_CYCLES + 1) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_WORDS - 1);
  localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t                          r_state;
  logic [NUM_WORDS*DATA_WIDTH-1:0] r_buf;
  logic [c_IDX_W-1:0]              r_word_idx;
  logic [c_GAP_W-1:0]              r_gap_cnt;

  logic                  w_last;
  logic                  w_acc;
  logic                  w_drop;
  logic [c_IDX_W-1:0]    w_next_idx;
  logic [DATA_WIDTH-1:0] w_next_word;

  // The eof cycle can take a new frame so frames may run back-to-back.
  assign w_last      = (r_state == SEND) && (r_word_idx == c_LAST_IDX);
  assign busy        = ~((r_state == IDLE) | w_last);
  assign w_acc       = frame_in_vld & ~busy;
  assign w_drop      = frame_in_vld & busy;
  assign w_next_idx  = r_word_idx + c_IDX_W'(1);
  assign w_next_word = r_buf[int'(w_next_idx)*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_buf        <= '0;
      r_word_idx   <= '0;
      r_gap_cnt    <= '0;
      data_out     <= '0;
      data_out_vld <= 1'b0;
      data_out_sof <= 1'b0;
      data_out_eof <= 1'b0;
    end else begin
      data_out_vld <= 1'b0;
      data_out_sof <= 1'b0;
      data_out_eof <= 1'b0;
      if (w_acc) begin
        // Word 0 goes straight from the input so it lands one cycle after the strobe.
        r_buf        <= frame_in;
        r_word_idx   <= '0;
        r_state      <= SEND;
        data_out     <= frame_in[DATA_WIDTH-1:0];
        data_out_vld <= 1'b1;
        data_out_sof <= 1'b1;
      end else begin
        case (r_state)
          IDLE: r_state <= IDLE;
          SEND: begin
            if (w_last) begin
              r_state <= IDLE;
            end else if (GAP_CYCLES == 0) begin
              r_word_idx   <= w_next_idx;
              data_out     <= w_next_word;
              data_out_vld <= 1'b1;
              data_out_eof <= (w_next_idx == c_LAST_IDX);
            end else begin
              r_state   <= GAP;
              r_gap_cnt <= c_GAP_LOAD;
            end
          end
          GAP: begin
            if (r_gap_cnt != '0) begin
              r_gap_cnt <= r_gap_cnt - c_GAP_W'(1);
            end else begin
              r_state      <= SEND;
              r_word_idx   <= w_next_idx;
              data_out     <= w_next_word;
              data_out_vld <= 1'b1;
              data_out_eof <= (w_next_idx == c_LAST_IDX);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  vld_word_serializer_sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_drop_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (w_drop),
    .count(drop_cnt)
  );

endmodule
`default_nettype wire

// File: doc/vld_word_serializer.md
Name: vld_word_serializer

Overview:
- Transmit-side counterpart of the valid-qualified capture registers used across the measurement datapath.
- Accepts one wide frame (NUM_WORDS packed words) on a single-cycle valid strobe.
- Emits the frame as a stream of DATA_WIDTH words, each qualified by a 1-cycle data_out_vld, with start/end-of-frame markers.
- Sits between the phase-sample assembly logic and downstream valid-only capture stages and the register/DMA path.

Parameters:
- DATA_WIDTH, 32, width of each output word.
- NUM_WORDS, 4, words per frame; legal range 2..256.
- GAP_CYCLES, 0, idle cycles (data_out_vld=0) inserted between consecutive words of one frame; legal range 0..255.
- CNT_WIDTH, 16, width of the dropped-frame counter.

Ports:
- clk, input, 1, clock.
- rstn, input, 1, synchronous active-low reset.
- frame_in, input, NUM_WORDS*DATA_WIDTH, packed frame; word k = frame_in[k*DATA_WIDTH +: DATA_WIDTH].
- frame_in_vld, input, 1, single-cycle frame strobe.
- busy, output, 1, combinational; high when a frame strobe this cycle would be dropped.
- data_out, output, DATA_WIDTH, current word; holds its last value when not valid.
- data_out_vld, output, 1, word qualifier, one cycle per word.
- data_out_sof, output, 1, high with word 0 only.
- data_out_eof, output, 1, high with word NUM_WORDS-1 only.
- drop_cnt, output, CNT_WIDTH, saturating count of frames strobed while busy.

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE, data_out=0, data_out_vld=0, sof=0, eof=0, drop_cnt=0, internal frame buffer=0, word/gap counters=0.
- Reset mid-frame aborts the frame. No further words are emitted, and outputs are zero from the next edge.
- States:
  - IDLE: no frame in flight.
  - SEND: a word is on the output this cycle (data_out_vld=1).
  - GAP: inter-word idle, used only when GAP_CYCLES>0.
- Accept condition: acc = frame_in_vld & ~busy.
  - busy = ~( state==IDLE | (state==SEND & word_idx==NUM_WORDS-1) ).
- On acc:
  - Latch frame_in into the buffer, set word_idx=0, go to SEND.
  - Word 0 appears on data_out with vld=1 and sof=1 at the next edge (latency 1 cycle).
- SEND, word_idx < NUM_WORDS-1:
  - If GAP_CYCLES==0, go to SEND with word_idx+1 next cycle.
  - Otherwise go to GAP with gap_cnt=GAP_CYCLES-1, and vld=0 while in GAP.
- GAP:
  - While gap_cnt != 0, decrement gap_cnt.
  - When gap_cnt==0, go to SEND with word_idx+1.
- SEND, word_idx==NUM_WORDS-1 (eof=1):
  - With acc, go directly to SEND word 0 of the new frame (back-to-back, no idle cycle, even when GAP_CYCLES>0).
  - Otherwise go to IDLE.
- A frame occupies NUM_WORDS + (NUM_WORDS-1)*GAP_CYCLES output cycles.
- NUM_WORDS words are always emitted per accepted frame, in order 0..NUM_WORDS-1. There is no partial frame except on reset.
- Dropped frames: if frame_in_vld & busy, the frame is discarded and the buffer is unaffected. drop_cnt increments and saturates at all-ones.
- frame_in_vld held high for several cycles counts as one strobe per cycle. Each accepted cycle is a frame, and each busy cycle is a drop.
- data_out holds its last word when vld=0, matching downstream hold semantics. sof and eof are only ever high together with vld.
- Widths:
  - word_idx is clog2(NUM_WORDS) bits.
  - gap_cnt is max(1, clog2(GAP_CYCLES+1)) bits.
  - Word selection is an indexed part-select of the buffer.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'd0, SEND=2'd1, GAP=2'd2);
  - the clog2 helper function;
  - the default DATA_WIDTH.
- One natural sub-module: sat_counter (parameterised width, synchronous active-low clear, increment enable, saturate at max), used for drop_cnt.
- The FSM, buffer and word mux stay in the top module.

Test Plan:
- Basic frame:
  - Stimulus: reset, then NUM_WORDS=4, GAP=0, strobe frame_in=0x44444444_33333333_22222222_11111111 once.
  - Required: words 0x11111111, 0x22222222, 0x33333333, 0x44444444 on 4 consecutive cycles starting 1 cycle after the strobe; sof on the first word, eof on the fourth; busy high for 3 cycles.
- Gap insertion:
  - Stimulus: GAP_CYCLES=2, same frame.
  - Required: vld pattern 1,0,0,1,0,0,1,0,0,1 (10 cycles); data_out holds the prior word during gaps.
- Back-to-back:
  - Stimulus: strobe frame A, then strobe frame B exactly on A's eof cycle.
  - Required: 8 contiguous valid cycles, B's word 0 carries sof immediately after A's eof; drop_cnt=0.
- Drop:
  - Stimulus: strobe a second frame 1 cycle after the first accept.
  - Required: drop_cnt=1; only the first frame's 4 words are emitted.
  - Additionally, with CNT_WIDTH=2 and 5 drops, drop_cnt=3 (saturated).
- Reset mid-frame:
  - Stimulus: assert rstn=0 during word 1.
  - Required: next edge data_out=0 and vld/sof/eof=0; no further words; after release, a new strobe is accepted normally.
- Sustained strobe:
  - Stimulus: frame_in_vld held high 6 cycles from IDLE.
  - Required: cycle 1 accepted, cycles 2-4 dropped, cycle 5 (eof cycle) accepted, cycle 6 dropped; drop_cnt=4.
